// File: rtl/alu_flag_writeback.sv
// ALU flag/writeback stage: flag register, condition check, commit/squash,
// and a 2-entry skid buffer in front of the register-file write port.
//
// Ports:
//   CLK, RST_N          clock, async active-low reset
//   IN_VALID/IN_READY   upstream handshake (IN_READY registered)
//   C,CO,OVF,N,Z        ALU result and flags
//   COND,S,WE_REQ,RD    condition code, set-flags, write request, dest reg
//   OUT_VALID/OUT_READY writeback handshake
//   WB_DATA,WB_ADDR,WB_EN  writeback entry
//   FLAGS               architectural flags {N,Z,CO,OVF}
//   SQUASH_CNT          saturating count of squashed instructions
module alu_flag_writeback #(
    parameter int W  = 4,
    parameter int AW = 3
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [W-1:0]  C,
    input  logic          CO,
    input  logic          OVF,
    input  logic          N,
    input  logic          Z,
    input  logic [3:0]    COND,
    input  logic          S,
    input  logic          WE_REQ,
    input  logic [AW-1:0] RD,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [W-1:0]  WB_DATA,
    output logic [AW-1:0] WB_ADDR,
    output logic          WB_EN,
    output logic [3:0]    FLAGS,
    output logic [7:0]    SQUASH_CNT
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  out_data_q;
    logic [AW-1:0] out_addr_q;
    logic          out_en_q;
    logic [W-1:0]  sk_data_q;
    logic [AW-1:0] sk_addr_q;
    logic          sk_en_q;
    logic [3:0]    flags_q;
    logic [7:0]    cnt_q;

    logic fn, fz, fc, fv;
    logic cond_pass;
    logic accept;
    logic retire;
    logic new_en;

    assign fn = flags_q[3];
    assign fz = flags_q[2];
    assign fc = flags_q[1];
    assign fv = flags_q[0];

    // Condition is judged against the flags as they stand before
    // this instruction's own update.
    always_comb begin
        cond_pass = 1'b0;
        unique case (COND)
            4'b0000: cond_pass = fz;
            4'b0001: cond_pass = !fz;
            4'b0010: cond_pass = fc;
            4'b0011: cond_pass = !fc;
            4'b0100: cond_pass = fn;
            4'b0101: cond_pass = !fn;
            4'b0110: cond_pass = fv;
            4'b0111: cond_pass = !fv;
            4'b1000: cond_pass = fc & !fz;
            4'b1001: cond_pass = !fc | fz;
            4'b1010: cond_pass = (fn == fv);
            4'b1011: cond_pass = (fn != fv);
            4'b1100: cond_pass = !fz & (fn == fv);
            4'b1101: cond_pass = fz | (fn != fv);
            4'b1110: cond_pass = 1'b1;
            4'b1111: cond_pass = 1'b0;
        endcase
    end

    assign accept = IN_VALID & in_ready_q;
    assign retire = out_valid_q & OUT_READY;
    assign new_en = cond_pass & WE_REQ;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_en_q    <= 1'b0;
            sk_data_q   <= '0;
            sk_addr_q   <= '0;
            sk_en_q     <= 1'b0;
            flags_q     <= 4'b0000;
            cnt_q       <= 8'd0;
        end else begin
            if (accept && cond_pass && S) begin
                flags_q <= {N, Z, CO, OVF};
            end
            if (accept && !cond_pass && (cnt_q != 8'hFF)) begin
                cnt_q <= cnt_q + 8'd1;
            end

            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        out_data_q  <= C;
                        out_addr_q  <= RD;
                        out_en_q    <= new_en;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && !retire) begin
                        // Output is stalled: park the new entry.
                        sk_data_q  <= C;
                        sk_addr_q  <= RD;
                        sk_en_q    <= new_en;
                        in_ready_q <= 1'b0;
                        state_q    <= FULL;
                    end else if (accept && retire) begin
                        out_data_q <= C;
                        out_addr_q <= RD;
                        out_en_q   <= new_en;
                    end else if (retire) begin
                        out_valid_q <= 1'b0;
                        out_en_q    <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (retire) begin
                        out_data_q <= sk_data_q;
                        out_addr_q <= sk_addr_q;
                        out_en_q   <= sk_en_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ONE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    out_en_q    <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= EMPTY;
                end
            endcase
        end
    end

    assign IN_READY   = in_ready_q;
    assign OUT_VALID  = out_valid_q;
    assign WB_DATA    = out_data_q;
    assign WB_ADDR    = out_addr_q;
    assign WB_EN      = out_en_q;
    assign FLAGS      = flags_q;
    assign SQUASH_CNT = cnt_q;

endmodule

// File: doc/alu_flag_writeback.md
Name: alu_flag_writeback

Overview:
- Pipeline stage directly downstream of the processor ALU.
- Captures the ALU result C and its flags CO/OVF/N/Z, holds the architectural flag register, and evaluates a 4-bit condition code against it. Each instruction is either committed or squashed, and the writeback (data, address, enable) is presented to the register file over a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with registered IN_READY.

Parameters:
W, 4, data width; must match the ALU width.
AW, 3, register-file address width.

Ports:
CLK  in  1  clock; all state updates on the rising edge.
RST_N  in  1  asynchronous reset, active-low.
IN_VALID  in  1  upstream ALU result valid.
IN_READY  out  1  stage can accept. Equals NOT skid_full, taken from a register.
C  in  W  ALU result.
CO  in  1  ALU carry. For subtract this is not-borrow.
OVF  in  1  ALU signed overflow.
N  in  1  ALU negative.
Z  in  1  ALU zero.
COND  in  4  condition code of this instruction.
S  in  1  instruction updates flags.
WE_REQ  in  1  instruction writes a register. Low for compare-type instructions.
RD  in  AW  destination register.
OUT_VALID  out  1  writeback entry valid.
OUT_READY  in  1  register file accepts the entry.
WB_DATA  out  W  result to write.
WB_ADDR  out  AW  destination.
WB_EN  out  1  commit write. Equals cond_pass AND WE_REQ of the entry.
FLAGS  out  4  architectural flags {N,Z,CO,OVF}.
SQUASH_CNT  out  8  count of squashed instructions; saturates at 255.

Behaviour:
- Reset (RST_N low, asynchronous): OUT_VALID=0, WB_DATA=0, WB_ADDR=0, WB_EN=0, FLAGS=0000, SQUASH_CNT=0, skid empty, so IN_READY=1. A reset mid-transfer discards both buffer entries; no partial writeback is emitted.
- Accept: an input is accepted when IN_VALID and IN_READY are both high at a clock edge. Nothing is sampled otherwise.
- Condition evaluation: performed at accept against the FLAGS value before this instruction's update (fN,fZ,fC,fV):
  - 0000 EQ: fZ. 0001 NE: !fZ. 0010 CS: fC. 0011 CC: !fC.
  - 0100 MI: fN. 0101 PL: !fN. 0110 VS: fV. 0111 VC: !fV.
  - 1000 HI: fC&!fZ. 1001 LS: !fC|fZ.
  - 1010 GE: fN==fV. 1011 LT: fN!=fV.
  - 1100 GT: !fZ&(fN==fV). 1101 LE: fZ|(fN!=fV).
  - 1110 AL: 1. 1111 NV: 0.
- Flag update: at the accept edge, if pass AND S, then FLAGS <= {N,Z,CO,OVF}. A squashed instruction never changes FLAGS.
- Back-to-back ordering: the next accepted instruction, one cycle later, sees the updated FLAGS. There is no bypass and no stall.
- Squash counting: on a squashed accept, SQUASH_CNT increments; it saturates at 255. A squashed entry still flows to the output with WB_EN=0, so ordering is preserved.
- Latency: 1 cycle. An entry accepted at edge t shows OUT_VALID=1 after edge t.
- Output handshake: the entry retires when OUT_VALID and OUT_READY are both high. The output is held stable while OUT_VALID=1 and OUT_READY=0.
- Skid buffer states: EMPTY (no output), ONE (output entry only), FULL (output entry plus skid entry).
  - EMPTY + accept -> ONE.
  - ONE + accept + no retire -> FULL; the new entry goes to skid.
  - ONE + accept + retire -> ONE; the new entry goes to output.
  - ONE + retire only -> EMPTY.
  - FULL + retire -> ONE; skid moves to output. No accept is possible in FULL since IN_READY=0.
  - IN_READY is low only in FULL.
- Widths: SQUASH_CNT is 8-bit unsigned and saturating. FLAGS bit order is fixed as {N,Z,CO,OVF}, bit 3 = N.

Test Plan:
- Reset: RST_N low mid-stream with both entries full -> outputs, FLAGS, and SQUASH_CNT are 0 immediately (asynchronously); IN_READY=1 after release.
- Flag and condition chain: accept C=0000,Z=1,S=1,COND=AL,WE_REQ=0 -> WB_EN=0, FLAGS=0100. Next cycle accept C=0011,COND=EQ,RD=2,WE_REQ=1 -> WB_EN=1, WB_DATA=0011, WB_ADDR=2.
- Squash: with FLAGS=0100, accept COND=NE,S=1,N=1,CO=1 -> WB_EN=0, FLAGS stays 0100, SQUASH_CNT=1.
- Signed conditions: set FLAGS=1000 (N=1, V=0). COND=LT passes, GE fails, LE passes, GT fails. Set FLAGS=1001 -> GE passes, GT passes.
- Backpressure: hold OUT_READY=0 and send 3 back-to-back inputs -> IN_READY drops after the 2nd accept and the 3rd waits. Release OUT_READY -> entries come out in order 1,2,3 with no loss and no duplicate.
- Saturation: 260 squashed instructions (COND=NV) -> SQUASH_CNT=255; FLAGS unchanged.
